// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, 16-entry branch-target LUT and
// the start/done run handshake. The instruction ROM sits outside; this block
// only watches the returned word for the halt encoding.
module fetch_unit #(
    parameter int          PC_W       = 10,
    parameter logic [8:0]  HALT_INSTR = 9'h1F0,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch,
    input  logic [3:0]       pc_immed,
    input  logic [8:0]       instr,
    input  logic             lut_we,
    input  logic [3:0]       lut_addr,
    input  logic [PC_W-1:0]  lut_data,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [PC_W-1:0]   lut_mem [16];

    logic [PC_W-1:0]   branch_target;
    logic              halt_seen;
    logic              pc_at_top;

    // Combinational read: a same-cycle write only lands at the edge, so a
    // branch to the entry being written still sees the old target.
    assign branch_target = lut_mem[pc_immed];
    assign halt_seen     = (instr == HALT_INSTR);
    assign pc_at_top     = &pc_reg;

    // Branch LUT entries: cleared by reset, otherwise written when addressed.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lut
            always_ff @(posedge clk) begin
                if (reset) begin
                    lut_mem[gi] <= '0;
                end else if (lut_we && (lut_addr == 4'(gi))) begin
                    lut_mem[gi] <= lut_data;
                end
            end
        end
    endgenerate

    // State, program counter and run counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, next-PC and next-count selection.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            S_RUN: begin
                // Every RUN cycle counts, stalled and halting ones included.
                if (!(&cnt_reg)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                // A stalled cycle freezes the PC and defers halt/branch/wrap.
                if (!stall) begin
                    if (halt_seen) begin
                        state_next = S_DONE;
                    end else if (branch) begin
                        pc_next = branch_target;
                    end else if (pc_at_top) begin
                        // Ran off the end of program space: stop rather than wrap.
                        state_next = S_DONE;
                    end else begin
                        pc_next = pc_reg + PC_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        running   = (state_reg == S_RUN);
        done      = (state_reg == S_DONE);
        prog_ctr  = pc_reg;
        cycle_cnt = cnt_reg;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_fetch_unit;

    localparam int         PC_W   = 10;
    localparam int         CNT_W  = 16;
    localparam logic [8:0] HALT   = 9'h1F0;
    localparam int         PC_MAX = (1 << PC_W) - 1;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, start, stall, branch, lut_we;
    logic [3:0]       pc_immed, lut_addr;
    logic [PC_W-1:0]  lut_data;
    logic [8:0]       instr;
    logic [PC_W-1:0]  prog_ctr;
    logic             running, done;
    logic [CNT_W-1:0] cycle_cnt;

    logic [8:0] rom [0:PC_MAX];
    assign instr = rom[prog_ctr];

    fetch_unit #(.PC_W(PC_W), .HALT_INSTR(HALT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch(branch), .pc_immed(pc_immed), .instr(instr),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .prog_ctr(prog_ctr), .running(running), .done(done),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: mode 0 = idle, 1 = running, 2 = finished.
    int m_mode, m_pc, m_cnt;
    int m_lut [16];

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        int target;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
            for (int i = 0; i < 16; i++) m_lut[i] = 0;
            return;
        end
        target = m_lut[pc_immed];
        if (lut_we) m_lut[lut_addr] = int'(lut_data);
        if (m_mode == 1) begin
            m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (!stall) begin
                if (rom[m_pc] == HALT)   m_mode = 2;
                else if (branch)         m_pc = target;
                else if (m_pc == PC_MAX) m_mode = 2;
                else                     m_pc = m_pc + 1;
            end
        end else if (start) begin
            m_mode = 1; m_pc = 0; m_cnt = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pc", int'(prog_ctr), m_pc);
        check("running", int'(running), int'(m_mode == 1));
        check("done", int'(done), int'(m_mode == 2));
        check("cnt", int'(cycle_cnt), m_cnt);
        $display("[TB] t=%0t pc=%0d run=%0b done=%0b cnt=%0d", $time, prog_ctr, running, done, cycle_cnt);
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; stall = 0; branch = 0; lut_we = 0;
        pc_immed = 0; lut_addr = 0; lut_data = 0;
    endtask

    task automatic fill_rom(input int halt_pct);
        for (int i = 0; i <= PC_MAX; i++) begin
            rom[i] = 9'($urandom_range(0, 511));
            if (rom[i] == HALT) rom[i] = 9'h000;
            if ($urandom_range(0, 99) < halt_pct) rom[i] = HALT;
        end
    endtask

    initial begin
        int c0;
        idle_inputs();
        fill_rom(0);
        rom[5] = HALT;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;

        // Reset state
        reset = 1; step(); step();
        check("rst_pc", int'(prog_ctr), 0);
        check("rst_running", int'(running), 0);
        check("rst_done", int'(done), 0);
        reset = 0;

        // Straight-line run that halts at PC 5
        start = 1; step(); start = 0;
        check("s1_pc0", int'(prog_ctr), 0);
        for (int i = 0; i < 20 && !done; i++) step();
        check("s1_done", int'(done), 1);
        check("s1_running", int'(running), 0);
        check("s1_pc", int'(prog_ctr), 5);
        check("s1_cnt", int'(cycle_cnt), 6);

        // Branch through LUT[3]=40
        rom[5] = 9'h001;
        lut_we = 1; lut_addr = 3; lut_data = 40; step(); lut_we = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 10 && prog_ctr != 2; i++) step();
        branch = 1; pc_immed = 3; step(); branch = 0;
        check("s2_branch", int'(prog_ctr), 40);
        step();
        check("s2_incr", int'(prog_ctr), 41);

        // Simultaneous write/branch to the same entry uses the old target
        lut_we = 1; lut_addr = 3; lut_data = 50; branch = 1; pc_immed = 3; step();
        lut_we = 0;
        check("s3_old", int'(prog_ctr), 40);
        step(); branch = 0;
        check("s3_new", int'(prog_ctr), 50);

        // Stall at PC 7 with branch and HALT present
        rom[7] = HALT;
        lut_we = 1; lut_addr = 5; lut_data = 7; step(); lut_we = 0;
        branch = 1; pc_immed = 5; step();
        check("s4_at7", int'(prog_ctr), 7);
        c0 = int'(cycle_cnt);
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        check("s4_hold_pc", int'(prog_ctr), 7);
        check("s4_still_run", int'(running), 1);
        check("s4_cnt", int'(cycle_cnt), c0 + 3);
        stall = 0; branch = 0; step();
        check("s4_done", int'(done), 1);
        check("s4_pc", int'(prog_ctr), 7);
        rom[7] = 9'h002;

        // Start ignored in RUN; reset mid-run clears everything incl. LUT
        start = 1; step(); start = 0;
        for (int i = 0; i < 20 && prog_ctr != 10; i++) step();
        start = 1; step(); start = 0;
        check("s5_start_in_run", int'(prog_ctr), 11);
        for (int i = 0; i < 20 && prog_ctr != 20; i++) step();
        check("s5_at20", int'(prog_ctr), 20);
        reset = 1; step(); reset = 0;
        check("s5_rst_pc", int'(prog_ctr), 0);
        check("s5_rst_run", int'(running), 0);
        check("s5_rst_cnt", int'(cycle_cnt), 0);
        start = 1; step(); start = 0;
        branch = 1; pc_immed = 3; step(); branch = 0;
        check("s5_lut_cleared", int'(prog_ctr), 0);

        // Run off the end of program space
        for (int i = 0; i < 1100 && !done; i++) step();
        check("s6_done", int'(done), 1);
        check("s6_pc", int'(prog_ctr), PC_MAX);
        start = 1; step(); start = 0;
        check("s6_restart_pc", int'(prog_ctr), 0);
        check("s6_restart_done", int'(done), 0);
        check("s6_restart_run", int'(running), 1);

        // Random traffic
        fill_rom(2);
        reset = 1; step(); reset = 0;
        for (int n = 0; n < 2000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 19) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            branch   = ($urandom_range(0, 5) == 0);
            pc_immed = 4'($urandom_range(0, 15));
            lut_we   = ($urandom_range(0, 3) == 0);
            lut_addr = 4'($urandom_range(0, 15));
            lut_data = PC_W'($urandom_range(0, PC_MAX));
            step();
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the control decoder.
- Owns the program counter, the 16-entry branch-target lookup table indexed by the decoder's 4-bit `pc_immed`, and the start/done run handshake.
- Drives `prog_ctr` to the external instruction ROM. The ROM's 9-bit word returns combinationally on `instr`, which the decoder consumes in the same cycle.
- The decoder's `Branch` and `pc_immed` feed back here to select the next PC.

Parameters:
- PC_W, 10, program counter and branch-target width.
- HALT_INSTR, 9'h1F0, instruction encoding that terminates a run (opcode 111, funct 11; unused by the decoder).
- CNT_W, 16, width of the run cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin a run from PC 0; sampled in IDLE or DONE.
- stall  in  1  hold the PC for this cycle.
- branch  in  1  taken-branch flag from the decoder.
- pc_immed  in  4  branch LUT index from the decoder.
- instr  in  9  current instruction word from the ROM at `prog_ctr`.
- lut_we  in  1  branch LUT write enable.
- lut_addr  in  4  branch LUT write index.
- lut_data  in  PC_W  branch LUT write data (absolute target).
- prog_ctr  out  PC_W  current program counter.
- running  out  1  high while in RUN.
- done  out  1  high in DONE; level, held until the next start or reset.
- cycle_cnt  out  CNT_W  RUN cycles elapsed in the current/last run.

Behaviour:
- Reset (synchronous, active-high, highest priority, legal at any time including mid-run):
  - state=IDLE, prog_ctr=0, running=0, done=0, cycle_cnt=0.
  - All 16 LUT entries cleared to 0.
- States:
  - IDLE: outputs hold reset values. start=1 -> RUN next cycle, prog_ctr=0, cycle_cnt=0.
  - RUN: running=1. Per-cycle priority, highest first:
    1. stall=1: prog_ctr holds; branch, HALT and the wrap check are ignored this cycle.
    2. instr==HALT_INSTR: -> DONE, prog_ctr holds, branch ignored.
    3. branch=1: prog_ctr <= LUT[pc_immed].
    4. Otherwise prog_ctr <= prog_ctr+1.
    - Wrap: if prog_ctr == 2^PC_W-1 on a non-stalled, non-branch cycle, go to DONE instead of wrapping to 0; prog_ctr holds.
    - start is ignored while in RUN.
  - DONE: running=0, done=1, prog_ctr and cycle_cnt frozen. start=1 -> RUN with prog_ctr=0, cycle_cnt=0, done=0 in the same transition edge.
- cycle_cnt:
  - Increments by 1 on every clock edge where state==RUN, stalled cycles included.
  - Saturates at all-ones.
  - The halting cycle counts.
- Branch LUT:
  - Write is synchronous at the clock edge when lut_we=1; allowed in any state except during reset.
  - Read is combinational on pc_immed.
  - Simultaneous write and branch to the same entry: the branch uses the old value; the new value is visible next cycle.
- Latency: a branch or increment decision in cycle N appears on prog_ctr in cycle N+1. The instruction at the new PC is presented by the ROM in the same cycle N+1.
- No registered instruction buffer: `instr` passes to the decoder externally; this block only observes it for HALT.

Test Plan:
- Reset then start pulse, ROM returning non-branch instructions at PCs 0..4 and HALT_INSTR at PC 5 -> prog_ctr 0,1,2,3,4,5, then done=1, running=0, prog_ctr=5, cycle_cnt=6.
- Write LUT[3]=10'd40, run; at PC 2 assert branch with pc_immed=3 -> prog_ctr=40 next cycle, then 41.
- lut_we with lut_addr=3, lut_data=50 in the same cycle as branch with pc_immed=3 (old value 40) -> prog_ctr=40. A repeat branch one cycle later -> 50.
- Assert stall for 3 cycles at PC 7, with branch=1 and HALT_INSTR present during the stall -> prog_ctr stays 7, state stays RUN, cycle_cnt advances by 3. After release, HALT is taken -> DONE.
- Assert reset at PC 20 mid-run -> next cycle prog_ctr=0, IDLE, cycle_cnt=0, LUT[3] reads 0. Asserting start while in RUN has no effect on prog_ctr.
- Let PC run to 1023 with no HALT -> DONE with prog_ctr=1023. A start in DONE -> prog_ctr=0, done=0, running=1 next cycle.
